lcd_show_glyph: RTL and testbench

//  Parametrised successor character renderer for the SPI LCD path: draws one font glyph at (start_x,start_y)

---
 rtl/lcd_pkg.sv | 54 +++++
 rtl/lcd_show_glyph_if.sv | 33 +++
 rtl/lcd_glyph_row_fetch.sv | 62 ++++++
 rtl/lcd_show_glyph.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_show_glyph.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte helpers for the LCD glyph renderer.
// Build option LCD_GLYPH_SCALE2_EN (see lcd_show_glyph) does not affect this package.
package lcd_pkg;

   localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
   localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
   localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   localparam logic [15:0] RGB565_BLACK = 16'h0000;
   localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB565_RED   = 16'hF800;
   localparam logic [15:0] RGB565_GREEN = 16'h07E0;
   localparam logic [15:0] RGB565_BLUE  = 16'h001F;

   localparam logic [3:0] WIN_BYTES = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WIN   = 3'd1,
      ST_FETCH = 3'd2,
      ST_PIX   = 3'd3,
      ST_DONE  = 3'd4
   } glyph_state_e;

   // Window-setup sequence: CASET xs..xe, RASET ys..ye, then RAMWR.
   function automatic logic [8:0] win_byte(input logic [3:0] idx,
                                           input logic [15:0] xs, input logic [15:0] xe,
                                           input logic [15:0] ys, input logic [15:0] ye);
      logic [8:0] b;
      case (idx)
         4'd0:    b = {DC_CMD,  LCD_CMD_CASET};
         4'd1:    b = {DC_DATA, xs[15:8]};
         4'd2:    b = {DC_DATA, xs[7:0]};
         4'd3:    b = {DC_DATA, xe[15:8]};
         4'd4:    b = {DC_DATA, xe[7:0]};
         4'd5:    b = {DC_CMD,  LCD_CMD_RASET};
         4'd6:    b = {DC_DATA, ys[15:8]};
         4'd7:    b = {DC_DATA, ys[7:0]};
         4'd8:    b = {DC_DATA, ye[15:8]};
         4'd9:    b = {DC_DATA, ye[7:0]};
         4'd10:   b = {DC_CMD,  LCD_CMD_RAMWR};
         default: b = {DC_CMD,  8'h00};
      endcase
      return b;
   endfunction

   function automatic logic [8:0] px_byte(input logic [15:0] color, input logic lo);
      return {DC_DATA, (lo ? color[7:0] : color[15:8])};
   endfunction

endpackage

// File: rtl/lcd_show_glyph_if.sv
// Request, font-ROM and SPI-writer signals of the glyph renderer; slave = renderer side.
interface lcd_show_glyph_if #(
   parameter int COORD_W = 9,
   parameter int ROM_AW  = 12,
   parameter int ROM_DW  = 8
);
   logic                start;
   logic [6:0]          ascii_num;
   logic [COORD_W-1:0]  start_x;
   logic [COORD_W-1:0]  start_y;
   logic [15:0]         fg_color;
   logic [15:0]         bg_color;
   logic [ROM_AW-1:0]   rom_addr;
   logic [ROM_DW-1:0]   rom_q;
   // Byte handshake: en_write pulses one cycle with lcd_data valid; lcd_data then holds
   // until the writer pulses wr_done, and wr_done with no byte outstanding is ignored.
   logic                wr_done;
   logic [8:0]          lcd_data;
   logic                en_write;
   logic                busy;
   logic                done;
   lcd_pkg::glyph_state_e dbg_state;

   modport master (
      output start, ascii_num, start_x, start_y, fg_color, bg_color, rom_q, wr_done,
      input  rom_addr, lcd_data, en_write, busy, done, dbg_state
   );

   modport slave (
      input  start, ascii_num, start_x, start_y, fg_color, bg_color, rom_q, wr_done,
      output rom_addr, lcd_data, en_write, busy, done, dbg_state
   );
endinterface

// File: rtl/lcd_glyph_row_fetch.sv
// Font ROM row fetcher: maps a character code and row to a ROM address, waits
// the ROM latency and hands back the row word with a one-cycle row_valid.
module lcd_glyph_row_fetch #(
   parameter int FONT_H     = 16,
   parameter int ROM_DW     = 8,
   parameter int ROM_AW     = 12,
   parameter int FONT_BASE  = 1140,
   parameter int FIRST_CHAR = 32,
   parameter int LAST_CHAR  = 126,
   parameter int REPL_CHAR  = 63,
   parameter int ROM_LAT    = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              fetch,
   input  logic [6:0]        code,
   input  logic [4:0]        row,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [ROM_DW-1:0] rom_q,
   output logic [ROM_DW-1:0] row_data,
   output logic              row_valid
);

   logic [6:0]  code_eff;
   logic [31:0] addr_full;
   logic [2:0]  lat_cnt;
   logic        waiting;

   always_comb begin
      code_eff = code;
      if (code < 7'(FIRST_CHAR) || code > 7'(LAST_CHAR))
         code_eff = 7'(REPL_CHAR);
      addr_full = 32'(FONT_BASE) + 32'(code_eff - 7'(FIRST_CHAR)) * 32'(FONT_H) + 32'(row);
   end

   // rom_q is taken ROM_LAT+1 edges after the address register updates.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rom_addr  <= '0;
         lat_cnt   <= '0;
         waiting   <= 1'b0;
         row_data  <= '0;
         row_valid <= 1'b0;
      end else begin
         row_valid <= 1'b0;
         if (fetch) begin
            rom_addr <= ROM_AW'(addr_full);
            lat_cnt  <= '0;
            waiting  <= 1'b1;
         end else if (waiting) begin
            if (lat_cnt == 3'(ROM_LAT)) begin
               row_data  <= rom_q;
               row_valid <= 1'b1;
               waiting   <= 1'b0;
            end else begin
               lat_cnt <= lat_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/lcd_show_glyph.sv
// Renders one font glyph as an LCD window-setup plus RGB565 pixel byte stream.
// Define LCD_GLYPH_SCALE2_EN to draw every font pixel as a 2x2 block.
module lcd_show_glyph import lcd_pkg::*; #(
   parameter int FONT_W     = 8,
   parameter int FONT_H     = 16,
   parameter int ROM_DW     = 8,
   parameter int ROM_AW     = 12,
   parameter int FONT_BASE  = 1140,
   parameter int FIRST_CHAR = 32,
   parameter int LAST_CHAR  = 126,
   parameter int REPL_CHAR  = 63,
   parameter int ROM_LAT    = 2,
   parameter int COORD_W    = 9
) (
   input logic              sys_clk,
   input logic              sys_rst_n,
   lcd_show_glyph_if.slave  gif
);

`ifdef LCD_GLYPH_SCALE2_EN
   localparam int SCALE = 2;
`else
   localparam int SCALE = 1;
`endif
   localparam int W_EFF = SCALE * FONT_W;
   localparam int H_EFF = SCALE * FONT_H;

   glyph_state_e         state;
   logic [8:0]           lcd_data_r;
   logic                 en_write_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 pending;
   logic [3:0]           win_idx;
   logic [4:0]           col;
   logic [4:0]           row;
   logic                 half;
   logic [6:0]           code_r;
   logic [COORD_W-1:0]   xs_r, xe_r, ys_r, ye_r;
   logic [15:0]          fg_r, bg_r;
   logic [ROM_DW-1:0]    shift_r;
   logic                 fetch_req;
   logic [ROM_DW-1:0]    row_data;
   logic                 row_valid;
   logic [15:0]          cur_color, next_color;
   logic                 px_repeat, line_repeat;
   logic [ROM_DW-1:0]    line_copy;
   logic                 lo_ack;

   assign cur_color  = shift_r[0] ? fg_r : bg_r;
   assign next_color = shift_r[1] ? fg_r : bg_r;
   assign lo_ack     = (state == ST_PIX) && pending && gif.wr_done && half;

`ifdef LCD_GLYPH_SCALE2_EN
   logic              dup_px, dup_line;
   logic [ROM_DW-1:0] save_r;

   assign px_repeat   = !dup_px;
   assign line_repeat = !dup_line;
   assign line_copy   = save_r;

   // Second copy of each pixel, and second line of each font row replayed from save_r.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dup_px   <= 1'b0;
         dup_line <= 1'b0;
         save_r   <= '0;
      end else begin
         if (state == ST_FETCH && row_valid)
            save_r <= row_data;
         if (lo_ack) begin
            dup_px <= !dup_px;
            if (dup_px && col == 5'(FONT_W-1))
               dup_line <= !dup_line;
         end
      end
   end
`else
   assign px_repeat   = 1'b0;
   assign line_repeat = 1'b0;
   assign line_copy   = '0;
`endif

   lcd_glyph_row_fetch #(
      .FONT_H(FONT_H), .ROM_DW(ROM_DW), .ROM_AW(ROM_AW), .FONT_BASE(FONT_BASE),
      .FIRST_CHAR(FIRST_CHAR), .LAST_CHAR(LAST_CHAR), .REPL_CHAR(REPL_CHAR), .ROM_LAT(ROM_LAT)
   ) u_fetch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .fetch     (fetch_req),
      .code      (code_r),
      .row       (row),
      .rom_addr  (gif.rom_addr),
      .rom_q     (gif.rom_q),
      .row_data  (row_data),
      .row_valid (row_valid)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         lcd_data_r <= '0;
         en_write_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pending    <= 1'b0;
         win_idx    <= '0;
         col        <= '0;
         row        <= '0;
         half       <= 1'b0;
         code_r     <= '0;
         xs_r       <= '0;
         xe_r       <= '0;
         ys_r       <= '0;
         ye_r       <= '0;
         fg_r       <= '0;
         bg_r       <= '0;
         shift_r    <= '0;
         fetch_req  <= 1'b0;
      end else begin
         en_write_r <= 1'b0;
         done_r     <= 1'b0;
         fetch_req  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gif.start) begin
                  code_r     <= gif.ascii_num;
                  xs_r       <= gif.start_x;
                  xe_r       <= gif.start_x + COORD_W'(W_EFF-1);
                  ys_r       <= gif.start_y;
                  ye_r       <= gif.start_y + COORD_W'(H_EFF-1);
                  fg_r       <= gif.fg_color;
                  bg_r       <= gif.bg_color;
                  win_idx    <= 4'd1;
                  row        <= '0;
                  col        <= '0;
                  half       <= 1'b0;
                  lcd_data_r <= {DC_CMD, LCD_CMD_CASET};
                  en_write_r <= 1'b1;
                  pending    <= 1'b1;
                  busy_r     <= 1'b1;
                  state      <= ST_WIN;
               end
            end
            ST_WIN: begin
               if (pending && gif.wr_done) begin
                  if (win_idx == WIN_BYTES) begin
                     pending   <= 1'b0;
                     fetch_req <= 1'b1;
                     state     <= ST_FETCH;
                  end else begin
                     lcd_data_r <= win_byte(win_idx, 16'(xs_r), 16'(xe_r), 16'(ys_r), 16'(ye_r));
                     en_write_r <= 1'b1;
                     win_idx    <= win_idx + 4'd1;
                  end
               end
            end
            ST_FETCH: begin
               if (row_valid) begin
                  shift_r    <= row_data;
                  col        <= '0;
                  half       <= 1'b0;
                  lcd_data_r <= px_byte(row_data[0] ? fg_r : bg_r, 1'b0);
                  en_write_r <= 1'b1;
                  pending    <= 1'b1;
                  state      <= ST_PIX;
               end
            end
            ST_PIX: begin
               if (pending && gif.wr_done) begin
                  if (!half) begin
                     half       <= 1'b1;
                     lcd_data_r <= px_byte(cur_color, 1'b1);
                     en_write_r <= 1'b1;
                  end else begin
                     half <= 1'b0;
                     if (px_repeat) begin
                        lcd_data_r <= px_byte(cur_color, 1'b0);
                        en_write_r <= 1'b1;
                     end else if (col != 5'(FONT_W-1)) begin
                        col        <= col + 5'd1;
                        shift_r    <= shift_r >> 1;
                        lcd_data_r <= px_byte(next_color, 1'b0);
                        en_write_r <= 1'b1;
                     end else if (line_repeat) begin
                        col        <= '0;
                        shift_r    <= line_copy;
                        lcd_data_r <= px_byte(line_copy[0] ? fg_r : bg_r, 1'b0);
                        en_write_r <= 1'b1;
                     end else if (row != 5'(FONT_H-1)) begin
                        col       <= '0;
                        row       <= row + 5'd1;
                        pending   <= 1'b0;
                        fetch_req <= 1'b1;
                        state     <= ST_FETCH;
                     end else begin
                        pending <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign gif.lcd_data  = lcd_data_r;
   assign gif.en_write  = en_write_r;
   assign gif.busy      = busy_r;
   assign gif.done      = done_r;
   assign gif.dbg_state = state;

endmodule

// File: tb/tb_lcd_show_glyph.sv
// Directed bench for lcd_show_glyph: sync font ROM model, SPI writer acking after
// a few cycles, byte/address scoreboard against a reference glyph model.
module tb_lcd_show_glyph;
   import lcd_pkg::*;

   localparam int FONT_W    = 8;
   localparam int FONT_H    = 16;
   localparam int ROM_DW    = 8;
   localparam int ROM_AW    = 12;
   localparam int FONT_BASE = 1140;
   localparam int ROM_LAT   = 2;
   localparam int COORD_W   = 9;
   localparam int BUDGET    = 20000;
`ifdef LCD_GLYPH_SCALE2_EN
   localparam int SC = 2;
`else
   localparam int SC = 1;
`endif

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   wr_cnt = 0;

   logic [8:0]        got_q[$];
   logic [8:0]        exp_q[$];
   logic [ROM_AW-1:0] addr_q[$];
   logic [ROM_AW-1:0] exp_addr_q[$];
   logic [ROM_AW-1:0] last_addr = '0;
   logic [7:0]        font_mem [0:4095];
   logic [7:0]        rom_p1, rom_p2;

   lcd_show_glyph_if #(.COORD_W(COORD_W), .ROM_AW(ROM_AW), .ROM_DW(ROM_DW)) gif ();

   lcd_show_glyph #(
      .FONT_W(FONT_W), .FONT_H(FONT_H), .ROM_DW(ROM_DW), .ROM_AW(ROM_AW),
      .FONT_BASE(FONT_BASE), .FIRST_CHAR(32), .LAST_CHAR(126), .REPL_CHAR(63),
      .ROM_LAT(ROM_LAT), .COORD_W(COORD_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .gif       (gif)
   );

   // ---------------- clock / reset ----------------
   always #5 sys_clk = ~sys_clk;

   // ---------------- font ROM model (two register stages) ----------------
   always @(posedge sys_clk) begin
      rom_p1 <= font_mem[gif.rom_addr];
      rom_p2 <= rom_p1;
   end
   assign gif.rom_q = rom_p2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- SPI writer model + monitors ----------------
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         wr_cnt = 0;
         gif.wr_done = 1'b0;
      end else begin
         gif.wr_done = 1'b0;
         if (wr_cnt != 0) begin
            wr_cnt--;
            if (wr_cnt == 0) gif.wr_done = 1'b1;
         end
         if (gif.en_write) begin
            check("en_write_while_outstanding", 32'(wr_cnt == 0 && !gif.wr_done), 32'd1);
            got_q.push_back(gif.lcd_data);
            wr_cnt = 3;
         end
         if (gif.done) done_cnt++;
         if (gif.busy && gif.rom_addr != last_addr) addr_q.push_back(gif.rom_addr);
      end
      last_addr = gif.rom_addr;
   end

   // ---------------- reference model ----------------
   task automatic build_exp(input int code, input int x, input int y,
                            input logic [15:0] fg, input logic [15:0] bg);
      int idx, xe, ye, a;
      logic [7:0]  rw;
      logic [15:0] c;
      idx = (code < 32 || code > 126) ? 31 : code - 32;
      xe = (x + FONT_W*SC - 1) % (1 << COORD_W);
      ye = (y + FONT_H*SC - 1) % (1 << COORD_W);
      exp_q = {};
      exp_addr_q = {};
      exp_q.push_back(9'h02A);
      exp_q.push_back({1'b1, 8'(x >> 8)});
      exp_q.push_back({1'b1, 8'(x)});
      exp_q.push_back({1'b1, 8'(xe >> 8)});
      exp_q.push_back({1'b1, 8'(xe)});
      exp_q.push_back(9'h02B);
      exp_q.push_back({1'b1, 8'(y >> 8)});
      exp_q.push_back({1'b1, 8'(y)});
      exp_q.push_back({1'b1, 8'(ye >> 8)});
      exp_q.push_back({1'b1, 8'(ye)});
      exp_q.push_back(9'h02C);
      for (int r = 0; r < FONT_H; r++) begin
         a = FONT_BASE + idx*FONT_H + r;
         exp_addr_q.push_back(ROM_AW'(a));
         rw = font_mem[a];
         for (int ly = 0; ly < SC; ly++)
            for (int p = 0; p < FONT_W*SC; p++) begin
               c = rw[p/SC] ? fg : bg;
               exp_q.push_back({1'b1, c[15:8]});
               exp_q.push_back({1'b1, c[7:0]});
            end
      end
   endtask

   // ---------------- driver: one glyph, scoreboard compare ----------------
   task automatic run_glyph(input int code, input int x, input int y,
                            input logic [15:0] fg, input logic [15:0] bg,
                            input bit disturb, input string tag);
      int n;
      got_q = {};
      addr_q = {};
      done_cnt = 0;
      build_exp(code, x, y, fg, bg);
      @(negedge sys_clk);
      gif.ascii_num = 7'(code);
      gif.start_x   = COORD_W'(x);
      gif.start_y   = COORD_W'(y);
      gif.fg_color  = fg;
      gif.bg_color  = bg;
      gif.start     = 1'b1;
      @(negedge sys_clk);
      gif.start = 1'b0;
      check({tag, "_busy_after_start"}, 32'(gif.busy), 32'd1);
      check({tag, "_first_en_write"}, 32'(gif.en_write), 32'd1);
      check({tag, "_first_byte"}, 32'(gif.lcd_data), 32'h02A);
      if (disturb) begin
         n = 0;
         while (got_q.size() < 20 && n < BUDGET) begin @(negedge sys_clk); n++; end
         check({tag, "_timeout_mid"}, 32'(n < BUDGET), 32'd1);
         gif.ascii_num = 7'd66;
         gif.start_x   = '0;
         gif.fg_color  = RGB565_BLUE;
         gif.bg_color  = RGB565_GREEN;
         gif.start     = 1'b1;
         @(negedge sys_clk);
         gif.start = 1'b0;
      end
      n = 0;
      while (gif.done !== 1'b1 && n < BUDGET) begin @(negedge sys_clk); n++; end
      check({tag, "_timeout_done"}, 32'(n < BUDGET), 32'd1);
      check({tag, "_busy_at_done"}, 32'(gif.busy), 32'd0);
      repeat (12) @(negedge sys_clk);
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check({tag, "_idle_after"}, 32'(gif.dbg_state), 32'(ST_IDLE));
      check({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      check({tag, "_addr_count"}, 32'(addr_q.size()), 32'(FONT_H));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            break;
         end
      for (int i = 0; i < exp_addr_q.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_addr_q[i]));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [8:0] win_a [11];
      logic [8:0] row81 [16];
      int n;
      win_a = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h111, 9'h02B, 9'h100, 9'h114, 9'h100, 9'h123, 9'h02C};
      for (int i = 0; i < 16; i++)
         row81[i] = (i < 2 || i >= 14) ? ((i % 2 == 0) ? 9'h1F8 : 9'h100) : 9'h1FF;
      for (int a = 0; a < 4096; a++) font_mem[a] = 8'((a * 29 + 7) ^ (a >> 3));
      font_mem[FONT_BASE + 33*FONT_H] = 8'h81;

      gif.start = 1'b0;
      gif.ascii_num = '0;
      gif.start_x = '0;
      gif.start_y = '0;
      gif.fg_color = '0;
      gif.bg_color = '0;
      repeat (3) @(negedge sys_clk);
      check("rst_en_write", 32'(gif.en_write), 32'd0);
      check("rst_busy", 32'(gif.busy), 32'd0);
      check("rst_done", 32'(gif.done), 32'd0);
      check("rst_lcd_data", 32'(gif.lcd_data), 32'd0);
      check("rst_rom_addr", 32'(gif.rom_addr), 32'd0);
      check("rst_state", 32'(gif.dbg_state), 32'(ST_IDLE));
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // 'A' at (10,20), red on white, with a second start and colour change mid-glyph
      run_glyph(65, 10, 20, RGB565_RED, RGB565_WHITE, 1'b1, "glyph_a");
      check("glyph_a_addr_first", 32'(addr_q[0]), 32'd1668);
      check("glyph_a_addr_last", 32'(addr_q[15]), 32'd1683);
`ifndef LCD_GLYPH_SCALE2_EN
      for (int i = 0; i < 11; i++)
         check($sformatf("glyph_a_win%0d", i), 32'(got_q[i]), 32'(win_a[i]));
      for (int i = 0; i < 16; i++)
         check($sformatf("glyph_a_row81_%0d", i), 32'(got_q[11+i]), 32'(row81[i]));
`endif

      // out-of-range codes fall back to '?'
      run_glyph(5, 0, 0, RGB565_GREEN, RGB565_BLACK, 1'b0, "repl_lo");
      check("repl_lo_addr_first", 32'(addr_q[0]), 32'd1636);
      run_glyph(127, 30, 40, RGB565_BLUE, RGB565_WHITE, 1'b0, "repl_hi");
      check("repl_hi_addr_first", 32'(addr_q[0]), 32'd1636);

      // column end wraps in COORD_W bits
      run_glyph(72, 508, 0, RGB565_WHITE, RGB565_BLACK, 1'b0, "wrap");
`ifndef LCD_GLYPH_SCALE2_EN
      check("wrap_xs_hi", 32'(got_q[1]), 32'h101);
      check("wrap_xs_lo", 32'(got_q[2]), 32'h1FC);
      check("wrap_xe_hi", 32'(got_q[3]), 32'h100);
      check("wrap_xe_lo", 32'(got_q[4]), 32'h103);
`endif

      // reset mid-glyph, then a clean render
      got_q = {};
      @(negedge sys_clk);
      gif.ascii_num = 7'd65;
      gif.start_x = 9'd100;
      gif.start_y = 9'd50;
      gif.start = 1'b1;
      @(negedge sys_clk);
      gif.start = 1'b0;
      n = 0;
      while (got_q.size() < 40 && n < BUDGET) begin @(negedge sys_clk); n++; end
      check("abort_timeout", 32'(n < BUDGET), 32'd1);
      sys_rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      check("abort_en_write", 32'(gif.en_write), 32'd0);
      check("abort_busy", 32'(gif.busy), 32'd0);
      check("abort_done", 32'(gif.done), 32'd0);
      check("abort_state", 32'(gif.dbg_state), 32'(ST_IDLE));
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      run_glyph(66, 200, 100, RGB565_RED, RGB565_BLUE, 1'b0, "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
